// File: rtl/run_controller_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the run controller: state encoding, memory byte
// strides and small helpers used to pick the next non-empty phase.
package run_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_I   = 3'd1,
        S_LOAD_D   = 3'd2,
        S_RUN      = 3'd3,
        S_DUMP_RD  = 3'd4,
        S_DUMP_WT  = 3'd5,
        S_DUMP_OUT = 3'd6
    } state_t;

    // Byte distance between consecutive words of each memory.
    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;

    // Saturate a requested length at the memory depth.
    function automatic logic [10:0] clamp_len(input logic [10:0] len, input logic [10:0] limit);
        return (len > limit) ? limit : len;
    endfunction

    // First phase after 'cur' whose length is non-zero; IDLE when nothing is left.
    function automatic state_t phase_after(input state_t cur, input logic has_i,
                                           input logic has_d, input logic has_r,
                                           input logic has_u);
        state_t nxt;
        nxt = S_IDLE;
        if (cur == S_IDLE && has_i)
            nxt = S_LOAD_I;
        else if ((cur inside {S_IDLE, S_LOAD_I}) && has_d)
            nxt = S_LOAD_D;
        else if ((cur inside {S_IDLE, S_LOAD_I, S_LOAD_D}) && has_r)
            nxt = S_RUN;
        else if ((cur inside {S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN}) && has_u)
            nxt = S_DUMP_RD;
        return nxt;
    endfunction

endpackage

// File: rtl/run_controller_ctrl_counter.sv
`timescale 1ns/1ps
// Loadable up/down counter; load wins over inc, inc wins over dec.
module ctrl_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = 1;

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (inc)
            count <= count + ONE;
        else if (dec)
            count <= count - ONE;
    end

endmodule

// File: rtl/run_controller.sv
`timescale 1ns/1ps
// Load/run/dump sequencer: streams host words into instruction and data
// memory, enables the CPU for a fixed number of cycles, then streams a
// region of data memory back to the host.
//
// Handshakes: a beat moves on a rising edge where valid && ready. in_ready
// and out_valid are decoded from registered state only, so neither depends
// combinationally on its partner's valid/ready; out_valid and out_data hold
// steady until out_ready is seen.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [9:0]  imem_len,
    input  logic [10:0] dmem_len,
    input  logic [10:0] dump_len,
    input  logic [31:0] run_cycles,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        cpu_enable,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic        done,
    output state_t      state_dbg
);

    state_t      state, next_state;
    logic [10:0] ilen_q, dlen_q, ulen_q;
    logic [31:0] rcyc_q;
    logic [10:0] ilen_in, dlen_in, ulen_in;
    logic [10:0] cur_i, cur_d, cur_u;
    logic [31:0] cur_r;
    logic        has_i, has_d, has_r, has_u;
    logic [10:0] idx;
    logic [31:0] timer;
    logic        beat;
    logic        idx_load, idx_inc, tmr_load, tmr_dec;

    assign ilen_in = clamp_len({1'b0, imem_len}, 11'(IMEM_WORDS));
    assign dlen_in = clamp_len(dmem_len, 11'(DMEM_WORDS));
    assign ulen_in = clamp_len(dump_len, 11'(DMEM_WORDS));

    // In IDLE the lengths are not latched yet, so phase skipping looks at the inputs.
    assign cur_i = (state == S_IDLE) ? ilen_in    : ilen_q;
    assign cur_d = (state == S_IDLE) ? dlen_in    : dlen_q;
    assign cur_u = (state == S_IDLE) ? ulen_in    : ulen_q;
    assign cur_r = (state == S_IDLE) ? run_cycles : rcyc_q;
    assign has_i = (cur_i != '0);
    assign has_d = (cur_d != '0);
    assign has_r = (cur_r != '0);
    assign has_u = (cur_u != '0);

    assign in_ready  = (state == S_LOAD_I) || (state == S_LOAD_D);
    assign beat      = in_valid && in_ready;
    assign state_dbg = state;

    // One index serves every phase; a second counter times the RUN window.
    ctrl_counter #(.W(11)) u_idx (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (idx_load),
        .load_val (11'd0),
        .inc      (idx_inc),
        .dec      (1'b0),
        .count    (idx)
    );

    ctrl_counter #(.W(32)) u_timer (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (tmr_load),
        .load_val (cur_r),
        .inc      (1'b0),
        .dec      (tmr_dec),
        .count    (timer)
    );

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next state, counter controls and memory/CPU port decode.
    always_comb begin
        next_state  = state;
        idx_load    = 1'b0;
        idx_inc     = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        cpu_enable  = 1'b0;
        busy        = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start)
                    next_state = phase_after(S_IDLE, has_i, has_d, has_r, has_u);
            end
            S_LOAD_I: begin
                wen_ext   = in_valid;
                wdata_ext = in_data[31:0];
                addr_ext  = 64'(idx) * 64'(IMEM_STRIDE);
                idx_inc   = beat;
                if (beat && idx == ilen_q - 11'd1)
                    next_state = phase_after(S_LOAD_I, has_i, has_d, has_r, has_u);
            end
            S_LOAD_D: begin
                wen_ext_2   = in_valid;
                wdata_ext_2 = in_data;
                addr_ext_2  = 64'(idx) * 64'(DMEM_STRIDE);
                idx_inc     = beat;
                if (beat && idx == dlen_q - 11'd1)
                    next_state = phase_after(S_LOAD_D, has_i, has_d, has_r, has_u);
            end
            S_RUN: begin
                cpu_enable = 1'b1;
                tmr_dec    = 1'b1;
                if (timer == 32'd1)
                    next_state = phase_after(S_RUN, has_i, has_d, has_r, has_u);
            end
            S_DUMP_RD: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = 64'(idx) * 64'(DMEM_STRIDE);
                next_state = S_DUMP_WT;
            end
            S_DUMP_WT: begin
                next_state = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (out_ready) begin
                    idx_inc    = 1'b1;
                    next_state = (idx == ulen_q - 11'd1) ? S_IDLE : S_DUMP_RD;
                end
            end
            default: next_state = S_IDLE;
        endcase

        // Entering a new phase restarts the index; DUMP_OUT->DUMP_RD continues it.
        idx_load = (next_state != state) && (state != S_DUMP_OUT) &&
                   (next_state inside {S_LOAD_I, S_LOAD_D, S_RUN, S_DUMP_RD});
        tmr_load = (next_state == S_RUN) && (state != S_RUN);
    end

    // Latched lengths, dump output register and the end-of-sequence pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ilen_q    <= '0;
            dlen_q    <= '0;
            ulen_q    <= '0;
            rcyc_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (next_state == S_IDLE) && ((state != S_IDLE) || start);
            if (state == S_IDLE && start) begin
                ilen_q <= ilen_in;
                dlen_q <= dlen_in;
                ulen_q <= ulen_in;
                rcyc_q <= run_cycles;
            end
            if (state == S_DUMP_WT) begin
                out_data  <= rdata_ext_2;
                out_valid <= 1'b1;
            end else if (state == S_DUMP_OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_run_controller.sv
`timescale 1ns/1ps
// Bench for run_controller: memory harness, event monitor with expected
// queues, a table of full-rate sequences, directed corner sequences and
// randomized sequences.
module tb_run_controller;
    import run_controller_pkg::*;

    localparam int IMEM_WORDS = 512;
    localparam int DMEM_WORDS = 1024;
    localparam int BUDGET     = 20000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic [9:0]  imem_len;
    logic [10:0] dmem_len, dump_len;
    logic [31:0] run_cycles;
    logic        in_valid, in_ready;
    logic [63:0] in_data;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2, out_data;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext;
    logic        cpu_enable, out_valid, out_ready, busy, done;
    state_t      state_dbg;

    always #5 clk = ~clk;

    run_controller #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len), .dump_len(dump_len), .run_cycles(run_cycles),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- data memory harness ----------------
    logic        mem_ready;
    logic [63:0] dmem       [DMEM_WORDS];
    logic [63:0] model_dmem [DMEM_WORDS];

    function automatic logic [63:0] init_word(input int i);
        return {32'hA5A5_0000 + 32'(i), ~32'(i)};
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= init_word(i);
        end else if (wen_ext_2) begin
            dmem[addr_ext_2[12:3]] <= wdata_ext_2;
        end
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0, cpu_cnt = 0, busy_cnt = 0;
    logic [95:0]  exp_iw_q[$];
    logic [127:0] exp_dw_q[$];
    logic [63:0]  exp_out_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write and dump word must be the next one the model expects.
    always @(negedge clk) begin
        if (arst_n) begin
            if (done)       done_cnt++;
            if (cpu_enable) cpu_cnt++;
            if (busy)       busy_cnt++;
            check("ren_ext_tied_low", 128'(ren_ext), 128'(0));
            check("cpu_enable_only_when_busy", 128'(cpu_enable & ~busy), 128'(0));
            if (wen_ext) begin
                check("wen_ext_has_beat", 128'(in_valid && in_ready), 128'(1));
                check("imem_write_expected", 128'(exp_iw_q.size() != 0), 128'(1));
                if (exp_iw_q.size() != 0)
                    check("imem_write_addr_data", 128'({addr_ext, wdata_ext}), 128'(exp_iw_q.pop_front()));
            end
            if (wen_ext_2) begin
                check("wen_ext_2_has_beat", 128'(in_valid && in_ready), 128'(1));
                check("dmem_write_expected", 128'(exp_dw_q.size() != 0), 128'(1));
                if (exp_dw_q.size() != 0)
                    check("dmem_write_addr_data", {addr_ext_2, wdata_ext_2}, exp_dw_q.pop_front());
            end
            if (out_valid && out_ready) begin
                check("dump_word_expected", 128'(exp_out_q.size() != 0), 128'(1));
                if (exp_out_q.size() != 0)
                    check("dump_word", 128'(out_data), 128'(exp_out_q.pop_front()));
            end
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic state_t model_first(input int ic, input int dc, input logic [31:0] rc, input int uc);
        if (ic > 0) return S_LOAD_I;
        if (dc > 0) return S_LOAD_D;
        if (rc > 0) return S_RUN;
        if (uc > 0) return S_DUMP_RD;
        return S_IDLE;
    endfunction

    // ---------------- driver ----------------
    // vmode: 0 always valid, 1 alternate 1,0,1,0, 2 random.
    // rmode: 0 always ready, 1 random, 2 hold ready low 10 cycles on first dump word.
    task automatic run_seq(input int il, input int dl, input int ul, input logic [31:0] rc,
                           input int vmode, input int rmode, input bit poke, input bit nop,
                           output state_t first, output int busy_seen);
        int ic, dc, uc, nbeats, beat, cyc, done0, cpu0, busy0, stall;
        logic [63:0] beats[$];
        logic [63:0] stall_data;
        logic [31:0] w;
        logic [63:0] d;
        logic acc, saw_run, poked;

        ic = (il > IMEM_WORDS) ? IMEM_WORDS : il;
        dc = (dl > DMEM_WORDS) ? DMEM_WORDS : dl;
        uc = (ul > DMEM_WORDS) ? DMEM_WORDS : ul;
        for (int k = 0; k < ic; k++) begin
            w = nop ? 32'h0000_0013 : $urandom;
            beats.push_back({$urandom, w});
            exp_iw_q.push_back({64'(k * 4), w});
        end
        for (int k = 0; k < dc; k++) begin
            d = {$urandom, $urandom};
            beats.push_back(d);
            exp_dw_q.push_back({64'(k * 8), d});
            model_dmem[k] = d;
        end
        for (int k = 0; k < uc; k++) exp_out_q.push_back(model_dmem[k]);

        done0 = done_cnt; cpu0 = cpu_cnt; busy0 = busy_cnt;
        @(posedge clk); #1;
        start = 1'b1; imem_len = 10'(il); dmem_len = 11'(dl); dump_len = 11'(ul); run_cycles = rc;
        @(posedge clk); #1;
        start = 1'b0;
        imem_len = 10'($urandom); dmem_len = 11'($urandom); dump_len = 11'($urandom);
        run_cycles = 32'($urandom_range(1, 50));

        nbeats = beats.size(); beat = 0; cyc = 0; stall = 0;
        saw_run = 1'b0; poked = 1'b0; first = S_IDLE; stall_data = '0; acc = 1'b0;
        while (done_cnt == done0 && cyc < BUDGET) begin
            case (vmode)
                0:       in_valid = (beat < nbeats);
                1:       in_valid = (beat < nbeats) && (cyc % 2 == 0);
                default: in_valid = (beat < nbeats) && ($urandom_range(1) == 1);
            endcase
            in_data = (beat < nbeats) ? beats[beat] : {$urandom, $urandom};
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(1) == 1);
                default: out_ready = (stall >= 10);
            endcase
            start = poke && saw_run && !poked;
            if (start) poked = 1'b1;
            @(negedge clk);
            if (cyc == 0) first = state_dbg;
            saw_run = (state_dbg == S_RUN);
            acc = in_valid && in_ready;
            if (rmode == 2 && stall > 0 && stall < 10) begin
                check("stall_out_valid_held", 128'(out_valid), 128'(1));
                check("stall_out_data_held", 128'(out_data), 128'(stall_data));
                check("stall_no_new_read", 128'(ren_ext_2), 128'(0));
                stall++;
            end else if (rmode == 2 && stall == 0 && out_valid) begin
                stall_data = out_data;
                stall = 1;
            end
            @(posedge clk); #1;
            if (acc) beat++;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("sequence_finished_in_budget", 128'(done_cnt != done0), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        check("done_pulse_count", 128'(done_cnt - done0), 128'(1));
        check("cpu_enable_cycles", 128'(cpu_cnt - cpu0), 128'(rc));
        check("imem_writes_outstanding", 128'(exp_iw_q.size()), 128'(0));
        check("dmem_writes_outstanding", 128'(exp_dw_q.size()), 128'(0));
        check("dump_words_outstanding", 128'(exp_out_q.size()), 128'(0));
        exp_iw_q.delete(); exp_dw_q.delete(); exp_out_q.delete();
        busy_seen = busy_cnt - busy0;
    endtask

    // ---------------- test table ----------------
    typedef struct {
        int          il, dl, ul;
        logic [31:0] rc;
        state_t      first;
        int          busy;
    } vec_t;

    vec_t   tbl[10];
    state_t first;
    int     bz;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full-rate sequences: busy = load beats + run cycles + 3 per dumped word.
        tbl[0] = '{3, 2, 2, 32'd5, S_LOAD_I, 16};
        tbl[1] = '{0, 0, 1, 32'd0, S_DUMP_RD, 3};
        tbl[2] = '{0, 2, 0, 32'd0, S_LOAD_D, 2};
        tbl[3] = '{0, 0, 0, 32'd4, S_RUN, 4};
        tbl[4] = '{0, 0, 0, 32'd0, S_IDLE, 0};
        tbl[5] = '{1023, 0, 0, 32'd0, S_LOAD_I, 512};
        tbl[6] = '{0, 2047, 0, 32'd0, S_LOAD_D, 1024};
        tbl[7] = '{0, 0, 2047, 32'd1, S_RUN, 3073};
        tbl[8] = '{1, 1, 1, 32'd1, S_LOAD_I, 6};
        tbl[9] = '{4, 0, 3, 32'd0, S_LOAD_I, 13};

        start = 1'b0; imem_len = '0; dmem_len = '0; dump_len = '0; run_cycles = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < DMEM_WORDS; i++) model_dmem[i] = init_word(i);

        // Reset: all outputs low even with a live-looking input stream.
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = '1; out_ready = 1'b1; start = 1'b1; imem_len = 10'd5;
        @(negedge clk);
        check("reset_state", 128'(state_dbg), 128'(S_IDLE));
        check("reset_in_ready", 128'(in_ready), 128'(0));
        check("reset_wen_ext", 128'(wen_ext), 128'(0));
        check("reset_wdata_ext", 128'(wdata_ext), 128'(0));
        check("reset_addr_ext", 128'(addr_ext), 128'(0));
        check("reset_wen_ext_2", 128'(wen_ext_2), 128'(0));
        check("reset_wdata_ext_2", 128'(wdata_ext_2), 128'(0));
        check("reset_ren_ext_2", 128'(ren_ext_2), 128'(0));
        check("reset_cpu_enable", 128'(cpu_enable), 128'(0));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_data", 128'(out_data), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        @(posedge clk); #1;
        start = 1'b0; imem_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        mem_ready = 1'b1; arst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table of full-rate sequences.
        for (int i = 0; i < 10; i++) begin
            run_seq(tbl[i].il, tbl[i].dl, tbl[i].ul, tbl[i].rc, 0, 0, 1'b0, (i == 0), first, bz);
            check($sformatf("tbl%0d_first_state", i), 128'(first), 128'(tbl[i].first));
            check($sformatf("tbl%0d_busy_cycles", i), 128'(bz), 128'(tbl[i].busy));
        end

        // in_valid alternating 1,0,1,0 through both load phases.
        run_seq(4, 3, 1, 32'd2, 1, 0, 1'b0, 1'b0, first, bz);
        check("alt_valid_first_state", 128'(first), 128'(S_LOAD_I));
        check("alt_valid_busy_cycles", 128'(bz), 128'(18));

        // out_ready held low for 10 cycles on the first dumped word.
        run_seq(0, 1, 2, 32'd0, 0, 2, 1'b0, 1'b0, first, bz);
        check("stall_first_state", 128'(first), 128'(S_LOAD_D));
        check("stall_busy_cycles", 128'(bz), 128'(17));

        // start pulsed during RUN is ignored.
        run_seq(1, 0, 1, 32'd6, 0, 0, 1'b1, 1'b0, first, bz);
        check("start_in_run_first_state", 128'(first), 128'(S_LOAD_I));
        check("start_in_run_busy_cycles", 128'(bz), 128'(10));

        // Reset pulsed mid-RUN, then a full sequence.
        @(posedge clk); #1;
        start = 1'b1; imem_len = '0; dmem_len = '0; dump_len = '0; run_cycles = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_reset_cpu_enable", 128'(cpu_enable), 128'(1));
        #2 arst_n = 1'b0;
        #1;
        check("async_reset_cpu_enable", 128'(cpu_enable), 128'(0));
        check("async_reset_busy", 128'(busy), 128'(0));
        check("async_reset_state", 128'(state_dbg), 128'(S_IDLE));
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk);
        run_seq(3, 2, 2, 32'd5, 0, 0, 1'b0, 1'b1, first, bz);
        check("after_reset_first_state", 128'(first), 128'(S_LOAD_I));
        check("after_reset_busy_cycles", 128'(bz), 128'(16));

        // Randomized sequences with throttled streams on both sides.
        for (int i = 0; i < 12; i++) begin
            int il, dl, ul;
            logic [31:0] rc;
            il = $urandom_range(0, 20);
            dl = $urandom_range(0, 20);
            ul = $urandom_range(0, 20);
            rc = 32'($urandom_range(0, 30));
            run_seq(il, dl, ul, rc, 2, 1, (ul > 0) && ($urandom_range(1) == 1), 1'b0, first, bz);
            check($sformatf("rand%0d_first_state", i), 128'(first), 128'(model_first(il, dl, rc, ul)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter IMEM_WORDS, default 512, is the instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 1024, is the data memory depth in 64-bit words.
REQ-003 clk  in  1  main clock; all state updates on rising edge.
REQ-004 arst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle request to begin a load/run/dump sequence.
REQ-006 imem_len  in  10  number of instruction words to load.
REQ-007 dmem_len  in  11  number of data words to preload.
REQ-008 dump_len  in  11  number of data words to read back after the run.
REQ-009 run_cycles  in  32  number of cycles cpu_enable stays high.
REQ-010 in_valid / in_ready / in_data  in / out / in  1 / 1 / 64  host load stream; a beat transfers when valid && ready.
REQ-011 addr_ext, wen_ext, ren_ext, wdata_ext  out  64, 1, 1, 32  instruction memory external port.
REQ-012 addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  out  64, 1, 1, 64  data memory external port.
REQ-013 rdata_ext_2  in  64  data memory read word, valid one cycle after ren_ext_2.
REQ-014 cpu_enable  out  1  drives the CPU enable input.
REQ-015 out_valid / out_ready / out_data  out / in / out  1 / 1 / 64  dump stream to host.
REQ-016 busy  out  1  high in every state except IDLE; done  out  1  one-cycle pulse on the return to IDLE.

Function
REQ-017 The FSM has states IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WT, DUMP_OUT.
REQ-018 In IDLE, a start pulse latches all four length inputs and enters LOAD_I; start is ignored in every other state.
REQ-019 Latched imem_len is clamped to IMEM_WORDS, and dmem_len and dump_len are clamped to DMEM_WORDS.
REQ-020 Any phase with a zero (clamped) length is skipped in the same transition, e.g. IDLE->LOAD_D when imem_len=0.
REQ-021 LOAD_I: in_ready=1; per accepted beat, wen_ext=1, wdata_ext=in_data[31:0], addr_ext=idx*4, idx++; after the last beat, go to LOAD_D.
REQ-022 LOAD_D: in_ready=1; per accepted beat, wen_ext_2=1, wdata_ext_2=in_data, addr_ext_2=idx*8; after the last beat, go to RUN.
REQ-023 The write enables are combinational on (state && in_valid) and are never asserted without an accepted beat.
REQ-024 RUN: cpu_enable=1 for exactly run_cycles consecutive cycles, counted by a 32-bit down-counter, then go to DUMP_RD; run_cycles=0 skips RUN.
REQ-025 DUMP_RD: ren_ext_2=1, addr_ext_2=idx*8 for one cycle -> DUMP_WT.
REQ-026 DUMP_WT: capture rdata_ext_2 into the out_data register, set out_valid -> DUMP_OUT.
REQ-027 DUMP_OUT: hold out_valid and out_data until out_ready; on handshake, idx++ and go to DUMP_RD, or after the last word go to IDLE with done=1.
REQ-028 Dump throughput is one word per 3 cycles when out_ready=1.
REQ-029 ren_ext is tied to 0; cpu_enable is 0 outside RUN; the external write enables are 0 outside the load states.
REQ-030 A single 11-bit index counter is reused across phases and cleared on every phase entry.

Reset
REQ-031 When arst_n=0, the FSM enters IDLE immediately.
REQ-032 During reset, all outputs, counters and latched lengths are 0, including cpu_enable, in_ready, out_valid, busy and done.
REQ-033 Reset asserted mid-sequence aborts the sequence with no further memory writes; the partially loaded memory contents are not restored.

Structure
REQ-034 The state encoding enum and the byte strides (4, 8) live in the shared CPU package.
REQ-035 The block is a single module; an optional sub-module is ctrl_counter, a loadable up/down counter used for idx and the run timer.
REQ-036 No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Verification
REQ-037 Load imem_len=3 (words 0x00000013 x3), dmem_len=2, run_cycles=5, dump_len=2 -> wen_ext at addresses 0, 4, 8; wen_ext_2 at 0, 8; cpu_enable high for exactly 5 cycles; the two dumped words match the preloaded ones; done pulses once.
REQ-038 in_valid toggled 1,0,1,0 during LOAD_I -> wen_ext only in valid cycles, and addresses stay contiguous.
REQ-039 imem_len=0, dmem_len=0, run_cycles=0, dump_len=1 -> goes IDLE->DUMP_RD directly, with one word dumped.
REQ-040 out_ready held 0 for 10 cycles in DUMP_OUT -> out_valid and out_data stable, and no new ren_ext_2.
REQ-041 start pulsed during RUN -> ignored, and the RUN length is unchanged.
REQ-042 arst_n pulsed low mid-RUN -> cpu_enable=0 and busy=0 asynchronously; the next start runs a full sequence.
